// File: rtl/frontier_pkg.sv
// Shared types and helpers for the frontier bitmap scanner.
// The entry word-index width tracks SCAN_WADDR_W; the scanner's WADDR_W must match it.
package frontier_pkg;

    localparam int WORD_W       = 32;
    localparam int BIT_IDX_W    = 5;
    localparam int MEM_RD_LAT   = 2;
    localparam int SCAN_WADDR_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [SCAN_WADDR_W-1:0] word_idx;
        logic [WORD_W-1:0]       data;
    } scan_entry_t;

    // Position of the lowest set bit; 0 for an all-zero word.
    function automatic logic [BIT_IDX_W-1:0] lowest_set(input logic [WORD_W-1:0] w);
        logic [BIT_IDX_W-1:0] pos;
        pos = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (w[i]) pos = BIT_IDX_W'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/scan_word_fifo.sv
// Buffers non-zero bitmap words returned by the BRAM until the extractor takes them.
// Latency: 1 cycle push-to-head.  Backpressure: push is dropped only when full without a pop;
// the upstream credit rule keeps that from happening, and push+pop at full is accepted.
module scan_word_fifo
    import frontier_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  scan_entry_t       din,
    input  logic              pop,
    output scan_entry_t       dout,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    scan_entry_t      store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign dout    = store[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/frontier_scan.sv
// Sweeps the frontier bitmap on BRAM port B and streams the ID of every set bit, ascending.
// Latency: first vid 5 cycles after start, then up to 1 vid/cycle.  Backpressure: vid held while
// vid_ready low; reads pause once FIFO + in-flight reach FIFO_DEPTH.  FRONTIER_SCAN_CLEAR_ON_READ_EN zeroes words as read.
module frontier_scan
    import frontier_pkg::*;
#(
    parameter int NUM_WORDS  = 2048,
    parameter int WADDR_W    = 11,
    parameter int MEM_ADDR_W = 18,
    parameter int VID_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_din,
    input  logic [WORD_W-1:0]     mem_dout,
    output logic                  vid_valid,
    input  logic                  vid_ready,
    output logic [VID_W-1:0]      vid,
    output logic [VID_W:0]        vid_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(MEM_RD_LAT + 1);
    localparam int SUM_W = CNT_W + 1;

    state_t             state;
    state_t             state_nx;
    logic [WADDR_W-1:0] rd_ptr;
    logic               issue;
    logic               start_ok;
    logic               credit_ok;

    logic [MEM_RD_LAT-1:0] pipe_vld;
    logic [WADDR_W-1:0]    pipe_idx [MEM_RD_LAT];
    logic [INF_W-1:0]      inflight;

    scan_entry_t        push_entry;
    scan_entry_t        head;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic [WORD_W-1:0]  cur_word;
    logic [WADDR_W-1:0] cur_idx;
    logic [WORD_W-1:0]  word_left;
    logic               fire;

    assign start_ok  = (state == IDLE) && start;
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_RD_LAT; i++) inflight = inflight + INF_W'(pipe_vld[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = ISSUE;
            ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (rd_ptr == WADDR_W'(NUM_WORDS - 1)) state_nx = DRAIN;
                end
            end
            DRAIN: if ((inflight == '0) && fifo_empty && (cur_word == '0)) state_nx = DONE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign mem_en   = issue;
    assign mem_addr = MEM_ADDR_W'(rd_ptr);
    assign mem_din  = '0;
`ifdef FRONTIER_SCAN_CLEAR_ON_READ_EN
    assign mem_we   = issue;
`else
    assign mem_we   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         rd_ptr <= '0;
        else if (start_ok) rd_ptr <= '0;
        else if (issue)    rd_ptr <= rd_ptr + WADDR_W'(1);
    end

    // Word index rides alongside each read so it arrives with mem_dout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < MEM_RD_LAT; i++) pipe_idx[i] <= '0;
        end else if (start_ok) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld    <= {pipe_vld[MEM_RD_LAT-2:0], issue};
            pipe_idx[0] <= rd_ptr;
            for (int i = 1; i < MEM_RD_LAT; i++) pipe_idx[i] <= pipe_idx[i-1];
        end
    end

    always_comb begin
        push_entry          = '0;
        push_entry.word_idx = pipe_idx[MEM_RD_LAT-1];
        push_entry.data     = mem_dout;
    end

    assign push = pipe_vld[MEM_RD_LAT-1] && (mem_dout != '0);

    scan_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign vid_valid = (cur_word != '0);
    assign vid       = {cur_idx, lowest_set(cur_word)};
    assign fire      = vid_valid && vid_ready;
    assign word_left = cur_word & (cur_word - WORD_W'(1));
    // Refill on the same edge the last bit leaves, so back-to-back words have no bubble.
    assign pop       = !fifo_empty && (!vid_valid || (fire && (word_left == '0)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_word <= '0;
            cur_idx  <= '0;
        end else if (pop) begin
            cur_word <= head.data;
            cur_idx  <= head.word_idx;
        end else if (fire) begin
            cur_word <= word_left;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                            vid_count <= '0;
        else if (start_ok)                                    vid_count <= '0;
        else if (fire && (vid_count != {(VID_W+1){1'b1}}))    vid_count <= vid_count + (VID_W+1)'(1);
    end

endmodule

// File: tb/tb_frontier_scan.sv
// Directed table of bitmap patterns plus randomized-backpressure and mid-sweep-reset sequences.
module tb_frontier_scan;

    localparam int NW         = 2048;
    localparam int WADDR_W    = 11;
    localparam int MEM_ADDR_W = 18;
    localparam int VID_W      = 16;
    localparam int FD         = 4;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  busy, done, mem_en, mem_we, vid_valid;
    logic                  vid_ready = 1'b0;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_din, mem_dout;
    logic [VID_W-1:0]      vid;
    logic [VID_W:0]        vid_count;

    always #5 clock = ~clock;

    frontier_scan #(
        .NUM_WORDS(NW), .WADDR_W(WADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .VID_W(VID_W), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .vid_valid(vid_valid), .vid_ready(vid_ready), .vid(vid),
        .vid_count(vid_count)
    );

    // BRAM port B model: 2-cycle read, read_first, plus backdoor fill/poke.
    logic [31:0] bmem [NW];
    logic [31:0] rd1 = '0, rd2 = '0;
    logic        bd_fill = 1'b0, bd_we = 1'b0;
    logic [31:0] bd_pat = '0, bd_data = '0;
    int          bd_addr = 0;

    always @(posedge clock) begin
        if (mem_en) rd1 <= bmem[mem_addr[WADDR_W-1:0]];
        rd2 <= rd1;
        if (bd_fill) begin
            for (int i = 0; i < NW; i++) bmem[i] <= bd_pat;
        end else if (bd_we) begin
            bmem[bd_addr] <= bd_data;
        end else if (mem_en && mem_we) begin
            bmem[mem_addr[WADDR_W-1:0]] <= mem_din;
        end
    end
    assign mem_dout = rd2;

    // Handshake monitor and hold-stability checker.
    logic [VID_W-1:0] got_vid[$];
    int               got_cyc[$];
    int               cyc = 0;
    bit               prev_stall = 1'b0;
    logic [VID_W-1:0] prev_vid = '0;
    int               stall_errs = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!vid_valid || vid != prev_vid)) stall_errs++;
            if (vid_valid && vid_ready) begin
                got_vid.push_back(vid);
                got_cyc.push_back(cyc);
            end
            prev_stall = vid_valid && !vid_ready;
            prev_vid   = vid;
        end
    end

    int tests = 0;
    int fails = 0;
    logic [VID_W-1:0] exp_vid[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input logic [31:0] p);
        bd_pat  = p;
        bd_fill = 1'b1;
        tick();
        bd_fill = 1'b0;
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic build_exp();
        exp_vid.delete();
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 32; b++)
                if (bmem[w][b]) exp_vid.push_back(VID_W'(w * 32 + b));
    endtask

    // mode 0: vid_ready high; mode 1: 3/4 random ready with a 100-cycle low stretch at n=300.
    task automatic run_sweep(input int mode, input int budget, output int lat, output int late);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("first_issue_en", mem_en, 1);
        chk("first_issue_addr", mem_addr, 0);
        chk("count_cleared", vid_count, 0);
        n    = 0;
        late = 0;
        while (!done && n < budget) begin
            if (mode == 0)                 vid_ready = 1'b1;
            else if (n >= 300 && n < 400)  vid_ready = 1'b0;
            else                           vid_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
            if (mode == 1 && n >= 300 + 2 * FD && n < 400 && mem_en) late++;
        end
        lat = n;
        chk("done_seen", done, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic check_stream(input int base, input string tag);
        int got_n, mism;
        got_n = got_vid.size() - base;
        chk({tag, "_handshakes"}, got_n, exp_vid.size());
        mism = 0;
        for (int k = 0; k < got_n && k < exp_vid.size(); k++)
            if (got_vid[base + k] != exp_vid[k]) mism++;
        chk({tag, "_order_mismatches"}, mism, 0);
    endtask

    typedef struct {
        int          wa;
        logic [31:0] da;
        int          wb;
        logic [31:0] db;
        int          exp_cnt;
        int          exp_first;
        int          exp_last;
        bit          chk_lat;
        bit          chk_b2b;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int lat, late, base, sbase, gaps, bad;
        vecs[0] = '{-1,   32'h0000_0000, -1,   32'h0000_0000, 0, 0,     0,     1'b1, 1'b0};
        vecs[1] = '{5,    32'h0000_0008, -1,   32'h0000_0000, 1, 163,   163,   1'b0, 1'b0};
        vecs[2] = '{0,    32'hFFFF_FFFF, 1,    32'h8000_0001, 34, 0,    63,    1'b0, 1'b1};
        vecs[3] = '{0,    32'h0000_0001, 2047, 32'h8000_0000, 2, 0,     65535, 1'b0, 1'b0};
        vecs[4] = '{1000, 32'h0001_0000, 1001, 32'h0000_0001, 2, 32016, 32032, 1'b0, 1'b0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_vid_count", vid_count, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            fill(32'h0);
            if (vecs[i].wa >= 0) poke(vecs[i].wa, vecs[i].da);
            if (vecs[i].wb >= 0) poke(vecs[i].wb, vecs[i].db);
            build_exp();
            base  = got_vid.size();
            run_sweep(0, 4000, lat, late);
            chk($sformatf("v%0d_vid_count", i), vid_count, vecs[i].exp_cnt);
            chk($sformatf("v%0d_handshakes", i), got_vid.size() - base, vecs[i].exp_cnt);
            check_stream(base, $sformatf("v%0d", i));
            if (vecs[i].exp_cnt > 0 && got_vid.size() > base) begin
                chk($sformatf("v%0d_first_vid", i), got_vid[base], vecs[i].exp_first);
                chk($sformatf("v%0d_last_vid", i), got_vid[got_vid.size() - 1], vecs[i].exp_last);
            end
            if (vecs[i].chk_lat) begin
                tests++;
                if (lat > NW + 3) begin
                    fails++;
                    $display("FAIL v%0d_done_latency: got %0d cycles, required <= %0d", i, lat, NW + 3);
                end
            end
            if (vecs[i].chk_b2b) begin
                gaps = 0;
                for (int k = base + 1; k < got_cyc.size(); k++)
                    if (got_cyc[k] - got_cyc[k-1] != 1) gaps++;
                chk($sformatf("v%0d_b2b_gaps", i), gaps, 0);
            end
        end

        // Dense pattern under random backpressure.
        fill(32'hAAAA_AAAA);
        build_exp();
        base  = got_vid.size();
        sbase = stall_errs;
        run_sweep(1, 60000, lat, late);
        chk("dense_vid_count", vid_count, 32768);
        check_stream(base, "dense");
        chk("dense_hold_violations", stall_errs - sbase, 0);
        chk("dense_issue_during_stall", late, 0);
        bad = 0;
        for (int w = 0; w < NW; w++) begin
`ifdef FRONTIER_SCAN_CLEAR_ON_READ_EN
            if (bmem[w] != 32'h0) bad++;
`else
            if (bmem[w] != 32'hAAAA_AAAA) bad++;
`endif
        end
        chk("dense_backdoor_words_wrong", bad, 0);

        // Reset in the middle of a sweep, then restart.
        fill(32'h0);
        poke(3, 32'h1);
        poke(900, 32'h1);
        vid_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!(mem_en && mem_addr == 700) && lat < 3000) begin
            tick();
            lat++;
        end
        chk("mid_reached_word_700", (mem_en && mem_addr == 700), 1);
        chk("mid_pre_reset_count", vid_count, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_mem_din", mem_din, 0);
        chk("mid_rst_vid_valid", vid_valid, 0);
        chk("mid_rst_vid", vid, 0);
        chk("mid_rst_vid_count", vid_count, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        build_exp();
        base = got_vid.size();
        run_sweep(0, 4000, lat, late);
`ifdef FRONTIER_SCAN_CLEAR_ON_READ_EN
        chk("restart_vid_count", vid_count, 1);
`else
        chk("restart_vid_count", vid_count, 2);
`endif
        check_stream(base, "restart");
        if (got_vid.size() > base)
            chk("restart_last_vid", got_vid[got_vid.size() - 1], 28800);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not reach the summary, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/frontier_scan.md
Name: frontier_scan

Overview:
- Initiator on the 32-bit port B of the visited/frontier bitmap BRAM (2-cycle read latency, read_first write mode).
- Sweeps the bitmap word by word and emits the index of every set bit as a vertex ID on a valid/ready stream.
- Feeds the next-level frontier into the PE dispatch logic.
- Optionally clears each word as it is read, so the bitmap is empty for the next BFS level.

Parameters:
- NUM_WORDS, 2048, bitmap depth in 32-bit words (65536 bits).
- WADDR_W, 11, word index width, equal to clog2(NUM_WORDS).
- MEM_ADDR_W, 18, memory port address width; the word index is zero-extended to this width.
- VID_W, 16, vertex ID width, equal to WADDR_W+5.
- FIFO_DEPTH, 4, returned-word buffer depth; must be at least 3.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a sweep when idle
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse when the sweep is complete
- mem_en  out  1  port B enable
- mem_we  out  1  port B write enable
- mem_addr  out  MEM_ADDR_W  port B address
- mem_din  out  32  port B write data; always 0
- mem_dout  in  32  port B read data, valid 2 cycles after mem_en
- vid_valid  out  1  vertex ID available
- vid_ready  in  1  consumer accepts the vertex ID
- vid  out  VID_W  vertex ID, equal to {word_idx, bit_idx}
- vid_count  out  VID_W+1  vertices emitted in the current sweep

Behaviour:
- Clock and reset: one clock, clock. reset is asynchronous and active-high.
- Reset values: every output is 0 and the FSM is in IDLE. Asserting reset mid-sweep aborts the sweep; bitmap contents are left as they are.
- FSM states:
  - IDLE: start moves to ISSUE and clears rd_ptr, vid_count and the in-flight tracker. start is ignored in every other state.
  - ISSUE: one read per cycle at rd_ptr while (fifo_count + inflight) < FIFO_DEPTH; each issue increments rd_ptr. After the read of word NUM_WORDS-1, go to DRAIN.
  - DRAIN: wait until inflight==0, FIFO empty and the current word is zero, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Read pipeline:
  - A 2-stage shift register carries {valid, word_idx} alongside each read; mem_dout is captured when stage 2 is valid.
  - Captured words equal to zero are dropped and never pushed to the FIFO.
  - The credit rule above makes FIFO overflow impossible under any vid_ready pattern.
- Extractor:
  - Registers cur_word and cur_idx, with vid_valid = (cur_word != 0).
  - vid = {cur_idx, position of the lowest set bit of cur_word}.
  - On vid_valid & vid_ready, clear that bit and increment vid_count.
  - If the cleared bit was the last one, load the FIFO head in the same cycle. This gives no bubble: a sustained 1 vertex/cycle with vid_ready held high.
  - vid and vid_valid stay stable while vid_valid=1 and vid_ready=0.
- Ordering: vertex IDs are emitted strictly ascending.
- Arithmetic: vid_count saturates at its maximum value; that value cannot be reached while NUM_WORDS*32 < 2^(VID_W+1).
- Simultaneous FIFO push and pop: legal at any fill level, including full-with-pop.

Optional Feature:
- Macro: FRONTIER_SCAN_CLEAR_ON_READ_EN.
- Defined: mem_we = mem_en on every read. read_first returns the old word and writes 0 in the same access, so the bitmap is all-zero after done.
- Undefined: mem_we is tied to 0 and the sweep is non-destructive.

Decomposition:
- Shared package frontier_pkg:
  - constants WORD_W=32, BIT_IDX_W=5, MEM_RD_LAT=2;
  - FSM state enum {IDLE, ISSUE, DRAIN, DONE};
  - typedef scan_entry_t = {word_idx, data}.
- Sub-module scan_word_fifo: synchronous FIFO of scan_entry_t, depth FIFO_DEPTH, with count output. The lowest-set-bit encoder is a package function, not a module.

Test Plan:
- All-zero bitmap, start: no vid_valid; done pulses after NUM_WORDS+3 cycles or fewer; vid_count=0.
- Only bit 3 of word 5 set: a single vid=163; vid_count=1; done follows.
- Word 0=0xFFFFFFFF, word 1=0x80000001, vid_ready=1: vids 0..31 on 32 consecutive cycles, then 32 and 63; vid_count=34.
- Every word 0xAAAAAAAA with vid_ready toggling pseudo-randomly, plus a 100-cycle low stretch: mem_en stops issuing within FIFO_DEPTH cycles; no loss or reordering; vid_count=32768.
- With FRONTIER_SCAN_CLEAR_ON_READ_EN, pattern as above: after done, a backdoor readback is all zero. Without the macro, the pattern is unchanged.
- Reset asserted mid-sweep at word 700, then start again: the sweep restarts at word 0; outputs were 0 during reset; vid_count restarts from 0.
